// File: rtl/i2c_if.sv
// Shared I2C bus: SCL from the controller, open-drain SDA resolved as a wired-AND
// of the controller and target pull-downs.
interface i2c_if;
    logic scl;
    logic ctrl_low;
    logic tgt_low;
    logic sda;

    assign sda = ~(ctrl_low | tgt_low);

    modport master (output scl, output ctrl_low, input sda);
    modport slave  (input scl, input sda, output tgt_low);
endinterface

// File: rtl/i2c_target.sv
// I2C target: 7-bit masked address match, read/write bursts, repeated START, stream-driven ACK/NACK.
// Optional feature macro GENERAL_CALL_EN: address 7'h00 with W also matches. HOLD_CYCLES must be >= 1.
module i2c_target #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
    parameter logic [6:0]  ADDR_MASK   = 7'h7F,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    i2c_if.slave       i2c,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_pop,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       addr_hit,
    output logic       rw_bit,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [7:0]             hold_cnt;
    logic [3:0]             cnt, cnt_n;
    logic [7:0]             shift, shift_n, rx_data_n, start_byte;
    logic                   sda_low, sda_low_n, rw_n, filler, filler_n, busy_n;
    logic                   hit_n, rxv_n, pop_n;
    logic                   scl_now, scl_old, sda_now, sda_old;
    logic                   scl_rise, scl_fall, start_cond, stop_cond, launch;
    logic                   addr_match, addr_ok, tx_fill;

    assign scl_now    = scl_sync[SYNC_STAGES-2];
    assign scl_old    = scl_sync[SYNC_STAGES-1];
    assign sda_now    = sda_sync[SYNC_STAGES-2];
    assign sda_old    = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_now & ~scl_old;
    assign scl_fall   = ~scl_now & scl_old;
    assign start_cond = scl_old & scl_now & sda_old & ~sda_now;
    assign stop_cond  = scl_old & scl_now & ~sda_old & sda_now;
    assign launch     = (hold_cnt == 8'd1);

    // shift holds {addr[6:0], rw} once the eighth address bit is in
`ifdef GENERAL_CALL_EN
    assign addr_match = (shift[7:1] == 7'd0) ? ~shift[0]
                      : (((shift[7:1] ^ SLAVE_ADDR) & ADDR_MASK) == 7'd0);
`else
    assign addr_match = (((shift[7:1] ^ SLAVE_ADDR) & ADDR_MASK) == 7'd0);
`endif
    assign addr_ok    = addr_match & (~shift[0] | tx_valid);
    assign tx_fill    = (state == TX_ACK) & ~tx_valid;
    assign start_byte = tx_fill ? 8'hFF : tx_data;

    assign i2c.tgt_low = sda_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            hold_cnt <= '0;
            state    <= IDLE;
            cnt      <= '0;
            shift    <= '0;
            sda_low  <= 1'b0;
            rw_bit   <= 1'b0;
            rx_data  <= '0;
            filler   <= 1'b0;
            busy     <= 1'b0;
            addr_hit <= 1'b0;
            rx_valid <= 1'b0;
            tx_pop   <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c.scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c.sda};
            if (start_cond || stop_cond)
                hold_cnt <= '0;
            else if (scl_fall)
                hold_cnt <= 8'(HOLD_CYCLES);
            else if (hold_cnt != 8'd0)
                hold_cnt <= hold_cnt - 8'd1;
            state    <= state_n;
            cnt      <= cnt_n;
            shift    <= shift_n;
            sda_low  <= sda_low_n;
            rw_bit   <= rw_n;
            rx_data  <= rx_data_n;
            filler   <= filler_n;
            busy     <= busy_n;
            addr_hit <= hit_n;
            rx_valid <= rxv_n;
            tx_pop   <= pop_n;
        end
    end

    // Bits are taken on SCL rise; every SDA change happens on the delayed launch strobe after SCL fall.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_n   = shift;
        sda_low_n = sda_low;
        rw_n      = rw_bit;
        rx_data_n = rx_data;
        filler_n  = filler;
        busy_n    = busy;
        hit_n     = 1'b0;
        rxv_n     = 1'b0;
        pop_n     = 1'b0;
        if (start_cond) begin
            state_n   = ADDR;
            cnt_n     = '0;
            sda_low_n = 1'b0;
            busy_n    = 1'b1;
        end else if (stop_cond) begin
            state_n   = IDLE;
            cnt_n     = '0;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ADDR, RX_BYTE: begin
                    if (scl_rise && cnt < 4'd8) begin
                        shift_n = {shift[6:0], sda_now};
                        cnt_n   = cnt + 4'd1;
                        if (state == RX_BYTE && cnt == 4'd7) begin
                            if (rx_ready) begin
                                rxv_n     = 1'b1;
                                rx_data_n = {shift[6:0], sda_now};
                            end else begin
                                state_n = WAIT_STOP;
                                cnt_n   = '0;
                            end
                        end
                    end else if (launch && cnt == 4'd8) begin
                        cnt_n = '0;
                        if (state == RX_BYTE) begin
                            sda_low_n = 1'b1;
                            state_n   = RX_ACK;
                        end else if (addr_ok) begin
                            sda_low_n = 1'b1;
                            hit_n     = 1'b1;
                            rw_n      = shift[0];
                            state_n   = ADDR_ACK;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK, TX_ACK: begin
                    if (state == TX_ACK && scl_rise && sda_now) begin
                        state_n = WAIT_STOP;
                    end else if (launch) begin
                        if (state == ADDR_ACK && !rw_bit) begin
                            sda_low_n = 1'b0;
                            state_n   = RX_BYTE;
                        end else begin
                            sda_low_n = ~start_byte[7];
                            shift_n   = {start_byte[6:0], 1'b0};
                            cnt_n     = 4'd1;
                            filler_n  = tx_fill;
                            state_n   = TX_BYTE;
                        end
                    end
                end
                RX_ACK: begin
                    if (launch) begin
                        sda_low_n = 1'b0;
                        state_n   = RX_BYTE;
                    end
                end
                TX_BYTE: begin
                    if (launch) begin
                        if (cnt < 4'd8) begin
                            sda_low_n = ~shift[7];
                            shift_n   = {shift[6:0], 1'b0};
                            cnt_n     = cnt + 4'd1;
                            pop_n     = (cnt == 4'd7) & ~filler;
                        end else begin
                            sda_low_n = 1'b0;
                            cnt_n     = '0;
                            state_n   = TX_ACK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller, stream models, and a queue scoreboard
// checked by a monitor on every addr_hit / rx_valid / tx_pop pulse.
module tb_i2c_target;
    localparam int Q = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid, tx_pop, rx_valid, rx_ready, addr_hit, rw_bit, busy;
    logic [7:0] tx_data, rx_data;

    int         checks = 0;
    int         errors = 0;
    int         lowcnt = 0;
    int         viol   = 0;
    logic       prev_low = 1'b0;

    logic [7:0] tx_q[$];
    logic [7:0] model_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_pop[$];
    logic       exp_hit[$];
    logic [7:0] wdata[4];
    logic       wready[4];

    i2c_if bus();

    i2c_target #(
        .SLAVE_ADDR (7'h42),
        .ADDR_MASK  (7'h7E),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i2c     (bus),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_pop  (tx_pop),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ready(rx_ready),
        .addr_hit(addr_hit),
        .rw_bit  (rw_bit),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Addresses 0x42/0x43 share the upper six bits with the target address (mask 7'h7E).
    function automatic logic model_match(input logic [6:0] a, input logic rw);
`ifdef GENERAL_CALL_EN
        if (a == 7'h00) return !rw;
`endif
        return (a >> 1) == (7'h42 >> 1);
    endfunction

    // Monitor and TX stream source share one negedge process so pops are checked before consumption.
    always @(negedge clk) begin
        if (!rst) begin
            if (addr_hit) begin
                if (exp_hit.size() == 0) chk("addr_hit_unexpected", 1, 0);
                else chk("rw_bit", rw_bit, exp_hit.pop_front());
            end
            if (rx_valid) begin
                if (exp_rx.size() == 0) chk("rx_valid_unexpected", 1, 0);
                else chk("rx_data", rx_data, exp_rx.pop_front());
            end
            if (tx_pop) begin
                if (exp_pop.size() == 0) chk("tx_pop_unexpected", 1, 0);
                else chk("tx_pop_byte", tx_data, exp_pop.pop_front());
            end
            if (bus.tgt_low) lowcnt++;
            if (bus.tgt_low && !prev_low && bus.scl) viol++;
        end
        prev_low = bus.tgt_low;
        if (tx_pop && tx_q.size() != 0) void'(tx_q.pop_front());
        tx_valid = (tx_q.size() != 0);
        tx_data  = tx_valid ? tx_q[0] : 8'h00;
    end

    task automatic push_tx(input logic [7:0] b);
        tx_q.push_back(b);
        model_tx.push_back(b);
    endtask

    task automatic write_bit(input logic v);
        #Q bus.ctrl_low = !v;
        #Q bus.scl = 1'b1;
        #(2*Q) bus.scl = 1'b0;
    endtask

    task automatic read_bit(output logic v);
        #Q bus.ctrl_low = 1'b0;
        #Q bus.scl = 1'b1;
        #Q v = bus.sda;
        #Q bus.scl = 1'b0;
    endtask

    task automatic bus_start();
        bus.scl = 1'b1;
        #Q bus.ctrl_low = 1'b1;
        #Q bus.scl = 1'b0;
    endtask

    task automatic bus_rep_start();
        #Q bus.ctrl_low = 1'b0;
        #Q bus.scl = 1'b1;
        #Q bus.ctrl_low = 1'b1;
        #Q bus.scl = 1'b0;
    endtask

    task automatic bus_stop();
        #Q bus.ctrl_low = 1'b1;
        #Q bus.scl = 1'b1;
        #Q bus.ctrl_low = 1'b0;
        #Q;
        chk("busy_after_stop", busy, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic nack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(nack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            b[i] = v;
        end
        write_bit(!ack);
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic rw, input logic rep, output logic ok);
        logic nack;
        ok = model_match(a, rw) && (!rw || model_tx.size() != 0);
        if (ok) exp_hit.push_back(rw);
        if (rep) bus_rep_start();
        else bus_start();
        chk("busy_after_start", busy, 1);
        send_byte({a, rw}, nack);
        chk("addr_ack", !nack, ok);
    endtask

    task automatic write_data(input int n);
        logic nack;
        for (int i = 0; i < n; i++) begin
            rx_ready = wready[i];
            if (wready[i]) exp_rx.push_back(wdata[i]);
            send_byte(wdata[i], nack);
            chk("data_ack", !nack, wready[i]);
            if (!wready[i]) break;
        end
        rx_ready = 1'b1;
    endtask

    task automatic read_data(input int n);
        logic [7:0] e, got;
        for (int i = 0; i < n; i++) begin
            if (model_tx.size() != 0) begin
                e = model_tx.pop_front();
                exp_pop.push_back(e);
            end else begin
                e = 8'hFF;
            end
            recv_byte(got, i != n - 1);
            chk("rd_data", got, e);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok, nack, v;
        logic [3:0] bits;
        rst = 1'b1;
        rx_ready = 1'b1;
        bus.scl = 1'b1;
        bus.ctrl_low = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_addr_hit", addr_hit, 0);
        chk("rst_tx_pop", tx_pop, 0);
        chk("rst_rw_bit", rw_bit, 0);
        chk("rst_sda_released", bus.tgt_low, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // write 0x84, A5, 3C
        wdata[0] = 8'hA5; wready[0] = 1'b1;
        wdata[1] = 8'h3C; wready[1] = 1'b1;
        addr_phase(7'h42, 1'b0, 1'b0, ok);
        if (ok) write_data(2);
        bus_stop();

        // read 0x85 from stream 11,22; ACK then NACK
        push_tx(8'h11);
        push_tx(8'h22);
        repeat (3) @(negedge clk);
        addr_phase(7'h42, 1'b1, 1'b0, ok);
        if (ok) read_data(2);
        bus_stop();
        chk("stream_drained", tx_q.size(), 0);

        // foreign address: NACK, SDA never pulled, busy held until STOP
        lowcnt = 0;
        addr_phase(7'h28, 1'b0, 1'b0, ok);
        chk("busy_wait_stop", busy, 1);
        bus_stop();
        chk("no_sda_drive_on_nack", lowcnt, 0);

        // write then repeated START read
        wdata[0] = 8'h01; wready[0] = 1'b1;
        addr_phase(7'h42, 1'b0, 1'b0, ok);
        if (ok) write_data(1);
        push_tx(8'h7E);
        addr_phase(7'h42, 1'b1, 1'b1, ok);
        if (ok) read_data(1);
        bus_stop();

        // rx_ready low: data NACKed, later bytes ignored until STOP
        wdata[0] = 8'h55; wready[0] = 1'b0;
        addr_phase(7'h42, 1'b0, 1'b0, ok);
        if (ok) write_data(1);
        send_byte(8'h99, nack);
        chk("wait_stop_nack", nack, 1);
        bus_stop();

        // reset in the middle of a TX byte (0xA0: fifth bit drives SDA low)
        push_tx(8'hA0);
        repeat (3) @(negedge clk);
        addr_phase(7'h42, 1'b1, 1'b0, ok);
        for (int i = 3; i >= 0; i--) begin
            read_bit(v);
            bits[i] = v;
        end
        chk("pre_rst_bits", bits, 4'hA);
        #Q;
        chk("pre_rst_sda_low", bus.tgt_low, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rst_sda_release", bus.tgt_low, 0);
        chk("rst_busy_clear", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus_stop();
        addr_phase(7'h42, 1'b1, 1'b0, ok);
        if (ok) read_data(1);
        bus_stop();

        // general call address
        wdata[0] = 8'h06; wready[0] = 1'b1;
        addr_phase(7'h00, 1'b0, 1'b0, ok);
        if (ok) write_data(1);
        bus_stop();

        // randomized transactions
        for (int t = 0; t < 16; t++) begin
            logic [6:0] a;
            logic       rw;
            int         n, k;
            case ($urandom % 4)
                0:       a = 7'h43;
                1:       a = 7'($urandom);
                default: a = 7'h42;
            endcase
            rw = 1'($urandom % 2);
            n  = 1 + int'($urandom % 3);
            if (rw) begin
                k = int'($urandom % 3);
                for (int j = 0; j < k; j++) push_tx(8'($urandom));
            end else begin
                for (int j = 0; j < n; j++) begin
                    wdata[j]  = 8'($urandom);
                    wready[j] = ($urandom % 5) != 0;
                end
            end
            repeat (3) @(negedge clk);
            addr_phase(a, rw, 1'b0, ok);
            if (ok) begin
                if (rw) read_data(n);
                else write_data(n);
            end
            bus_stop();
        end

        repeat (20) @(negedge clk);
        chk("left_exp_rx", exp_rx.size(), 0);
        chk("left_exp_hit", exp_hit.size(), 0);
        chk("left_exp_pop", exp_pop.size(), 0);
        chk("stream_depth", tx_q.size(), model_tx.size());
        chk("sda_low_while_scl_high", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
